// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time programmable serial pattern detector.
// A pattern, length, match target and no-match timeout are loaded over a
// valid/ready handshake; start arms the engine, which then scans the
// qualified bit stream, pulses match per occurrence and stops on target or
// timeout.
// Optional build macro: SEQ_DETECT_OVERLAP_EN adds the cfg_overlap input so
// overlapping occurrences can be counted.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | not armed; config may be loaded; start arms once configured
// ARMED  | scanning din, counting matches and timeout cycles
// DONE   | target reached or timed out; outputs held; start re-arms
module seq_detect_ctrl #(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 8,
    parameter  int TMO_W = 16,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TMO_W-1:0] cfg_timeout,
`ifdef SEQ_DETECT_OVERLAP_EN
    input  logic             cfg_overlap,
`endif
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    input  logic             din_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_t state, state_next;

    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic [CNT_W-1:0] tgt_r;
    logic [TMO_W-1:0] tmo_r;
    logic             ovl_r;

    logic [PAT_W-1:0] hist, hist_shift, mask;
    logic [LEN_W-1:0] fill, fill_inc, len_in;
    logic [TMO_W-1:0] tmo_cnt, tmo_inc;
    logic             cfg_acc, hit, tgt_hit, tmo_hit, arm;

    assign cfg_ready = (state == S_IDLE) || (state == S_DONE);
    assign busy      = (state == S_ARMED);
    assign cfg_acc   = cfg_valid && cfg_ready;

    // Length 0 means "unconfigured" internally, so 0 and oversize both map to PAT_W.
    assign len_in = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;

    assign hist_shift = {hist[PAT_W-2:0], din};
    assign fill_inc   = (fill >= LEN_MAX) ? LEN_MAX : fill + LEN_W'(1);
    assign tmo_inc    = tmo_cnt + TMO_W'(1);

    // Compare mask selecting the low len_r history/pattern bits.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_r));
        end
    end

    // Abort suppresses a match completing on the same edge.
    assign hit = (state == S_ARMED) && din_valid && !abort &&
                 (fill_inc >= len_r) &&
                 (((hist_shift ^ pat_r) & mask) == '0);
    assign tgt_hit = hit && ((match_count + CNT_W'(1)) >= tgt_r);
    // A match on the same edge restarts the window, so it wins over timeout.
    assign tmo_hit = (state == S_ARMED) && !abort && !hit &&
                     (tmo_r != '0) && (tmo_inc == tmo_r);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; arm flags the edge that (re)starts a scan.
    always_comb begin
        state_next = state;
        arm        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!abort && start && (len_r != '0)) begin
                    state_next = S_ARMED;
                    arm        = 1'b1;
                end
            end
            S_ARMED: begin
                if (abort)        state_next = S_IDLE;
                else if (tgt_hit) state_next = S_DONE;
                else if (tmo_hit) state_next = S_DONE;
            end
            S_DONE: begin
                if (abort) state_next = S_IDLE;
                else if (start) begin
                    state_next = S_ARMED;
                    arm        = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Configuration registers, loaded on every accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r <= '0;
            len_r <= '0;
            tgt_r <= '0;
            tmo_r <= '0;
            ovl_r <= 1'b0;
        end else if (cfg_acc) begin
            pat_r <= cfg_pattern;
            len_r <= len_in;
            tgt_r <= (cfg_target == '0) ? CNT_W'(1) : cfg_target;
            tmo_r <= cfg_timeout;
`ifdef SEQ_DETECT_OVERLAP_EN
            ovl_r <= cfg_overlap;
`else
            ovl_r <= 1'b0;
`endif
        end
    end

    // Scan datapath: history, fill count, timeout counter, match bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            tmo_cnt     <= '0;
            match_count <= '0;
            match       <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            match <= hit;
            if (arm) begin
                hist        <= '0;
                fill        <= '0;
                tmo_cnt     <= '0;
                match_count <= '0;
                done        <= 1'b0;
                timeout     <= 1'b0;
            end else if ((state == S_ARMED) && !abort) begin
                tmo_cnt <= hit ? '0 : tmo_inc;
                if (din_valid) begin
                    hist <= hist_shift;
                    fill <= (hit && !ovl_r) ? '0 : fill_inc;
                end
                if (hit)     match_count <= match_count + CNT_W'(1);
                if (tgt_hit) done        <= 1'b1;
                if (tmo_hit) timeout     <= 1'b1;
            end
            if ((state != S_IDLE) && abort) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end
            if ((state == S_DONE) && cfg_acc) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl; expected match pulses are queued as
// each bit is driven and popped against the DUT one edge later.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int TMO_W = 16;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [CNT_W-1:0] cfg_target = '0;
    logic [TMO_W-1:0] cfg_timeout = '0;
    logic             cfg_overlap = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;
    logic             timeout;

    int n_assert = 0;
    int n_fail   = 0;
    logic exp_q[$];

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_timeout (cfg_timeout),
`ifdef SEQ_DETECT_OVERLAP_EN
        .cfg_overlap (cfg_overlap),
`endif
        .start       (start),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                       input logic [CNT_W-1:0] t, input logic [TMO_W-1:0] to,
                       input logic ov);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_target  = t;
        cfg_timeout = to;
        cfg_overlap = ov;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input string tag, input logic d, input logic v, input logic exp_m);
        din       = d;
        din_valid = v;
        exp_q.push_back(exp_m);
        tick();
        din_valid = 1'b0;
        chk(tag, {31'd0, match}, {31'd0, exp_q.pop_front()});
    endtask

    initial begin
        // reset
        tick();
        tick();
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        chk("rst_match", {31'd0, match}, 0);
        chk("rst_count", {24'd0, match_count}, 0);
        rst = 1'b0;

        // start with no config is ignored
        do_start();
        chk("nocfg_start_busy", {31'd0, busy}, 0);

        // basic 1101 detect, target 1
        cfg(8'b0000_1101, 4'd4, 8'd1, 16'd0, 1'b0);
        chk("cfg_idle_ready", {31'd0, cfg_ready}, 1);
        do_start();
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_ready_armed", {31'd0, cfg_ready}, 0);
        send("t1_b1", 1'b0, 1'b1, 1'b0);
        send("t1_b2", 1'b1, 1'b1, 1'b0);
        send("t1_b3", 1'b1, 1'b1, 1'b0);
        send("t1_b4", 1'b0, 1'b1, 1'b0);
        send("t1_b5", 1'b1, 1'b1, 1'b1);
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_count", {24'd0, match_count}, 1);
        chk("t1_busy_done", {31'd0, busy}, 0);
        send("t1_done_ignore", 1'b1, 1'b1, 1'b0);
        chk("t1_done_held", {31'd0, done}, 1);

        // cfg accept in DONE clears done; non-overlap target 3
        cfg(8'b0000_1101, 4'd4, 8'd3, 16'd0, 1'b0);
        chk("done_cfg_clr", {31'd0, done}, 0);
        chk("done_cfg_stay", {31'd0, cfg_ready}, 1);
        do_start();
        chk("t2_rearm_count", {24'd0, match_count}, 0);
        send("t2_b1", 1'b1, 1'b1, 1'b0);
        send("t2_b2", 1'b1, 1'b1, 1'b0);
        send("t2_b3", 1'b0, 1'b1, 1'b0);
        send("t2_b4", 1'b1, 1'b1, 1'b1);
        send("t2_b5", 1'b1, 1'b1, 1'b0);
        send("t2_b6", 1'b0, 1'b1, 1'b0);
        send("t2_b7", 1'b1, 1'b1, 1'b0);
        chk("t2_count", {24'd0, match_count}, 1);
        chk("t2_busy", {31'd0, busy}, 1);

        // abort in ARMED keeps count
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_count_kept", {24'd0, match_count}, 1);

        // din_valid gap mid-pattern
        cfg(8'b0000_1101, 4'd4, 8'd1, 16'd0, 1'b0);
        do_start();
        send("gap_b1", 1'b1, 1'b1, 1'b0);
        send("gap_b2", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send("gap_idle", 1'b1, 1'b0, 1'b0);
        send("gap_b3", 1'b0, 1'b1, 1'b0);
        send("gap_b4", 1'b1, 1'b1, 1'b1);
        chk("gap_done", {31'd0, done}, 1);

        // abort on the completing bit
        do_start();
        send("ab_b1", 1'b1, 1'b1, 1'b0);
        send("ab_b2", 1'b1, 1'b1, 1'b0);
        send("ab_b3", 1'b0, 1'b1, 1'b0);
        abort = 1'b1;
        send("ab_b4_abort", 1'b1, 1'b1, 1'b0);
        abort = 1'b0;
        chk("ab_busy", {31'd0, busy}, 0);
        chk("ab_done", {31'd0, done}, 0);
        chk("ab_count", {24'd0, match_count}, 0);
        do_start();
        chk("ab_rearm_busy", {31'd0, busy}, 1);
        send("ab_r1", 1'b1, 1'b1, 1'b0);
        send("ab_r2", 1'b1, 1'b1, 1'b0);
        send("ab_r3", 1'b0, 1'b1, 1'b0);
        send("ab_r4", 1'b1, 1'b1, 1'b1);
        chk("ab_r_done", {31'd0, done}, 1);

        // timeout after 5 ARMED cycles of zeros
        cfg(8'b0000_1101, 4'd4, 8'd1, 16'd5, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) send("tmo_zero", 1'b0, 1'b1, 1'b0);
        chk("tmo_busy_4", {31'd0, busy}, 1);
        chk("tmo_flag_4", {31'd0, timeout}, 0);
        send("tmo_zero5", 1'b0, 1'b1, 1'b0);
        chk("tmo_flag", {31'd0, timeout}, 1);
        chk("tmo_done", {31'd0, done}, 0);
        chk("tmo_busy", {31'd0, busy}, 0);
        chk("tmo_count", {24'd0, match_count}, 0);

        // target match on the timeout edge: match wins
        cfg(8'b0000_1101, 4'd4, 8'd1, 16'd4, 1'b0);
        chk("tmo_cfg_clr", {31'd0, timeout}, 0);
        do_start();
        send("tie_b1", 1'b1, 1'b1, 1'b0);
        send("tie_b2", 1'b1, 1'b1, 1'b0);
        send("tie_b3", 1'b0, 1'b1, 1'b0);
        send("tie_b4", 1'b1, 1'b1, 1'b1);
        chk("tie_done", {31'd0, done}, 1);
        chk("tie_timeout", {31'd0, timeout}, 0);

        // target 2 with back-to-back occurrences
        cfg(8'b0000_1101, 4'd4, 8'd2, 16'd0, 1'b0);
        do_start();
        for (int r = 0; r < 2; r++) begin
            send("tg2_b1", 1'b1, 1'b1, 1'b0);
            send("tg2_b2", 1'b1, 1'b1, 1'b0);
            send("tg2_b3", 1'b0, 1'b1, 1'b0);
            send("tg2_b4", 1'b1, 1'b1, 1'b1);
            chk("tg2_done_step", {31'd0, done}, (r == 1) ? 1 : 0);
        end
        chk("tg2_count", {24'd0, match_count}, 2);

        // len 0 clamps to PAT_W, target 0 stored as 1
        cfg(8'hA5, 4'd0, 8'd0, 16'd0, 1'b0);
        do_start();
        begin
            logic [7:0] pv;
            pv = 8'hA5;
            for (int i = 7; i >= 0; i--) send("clamp_bit", pv[i], 1'b1, (i == 0));
        end
        chk("clamp_done", {31'd0, done}, 1);
        chk("clamp_count", {24'd0, match_count}, 1);

`ifdef SEQ_DETECT_OVERLAP_EN
        cfg(8'b0000_1101, 4'd4, 8'd3, 16'd0, 1'b1);
        do_start();
        send("ov_b1", 1'b1, 1'b1, 1'b0);
        send("ov_b2", 1'b1, 1'b1, 1'b0);
        send("ov_b3", 1'b0, 1'b1, 1'b0);
        send("ov_b4", 1'b1, 1'b1, 1'b1);
        send("ov_b5", 1'b1, 1'b1, 1'b0);
        send("ov_b6", 1'b0, 1'b1, 1'b0);
        send("ov_b7", 1'b1, 1'b1, 1'b1);
        chk("ov_count", {24'd0, match_count}, 2);
        chk("ov_busy", {31'd0, busy}, 1);
`endif

        // reset mid-operation clears config too
        cfg(8'b0000_1101, 4'd4, 8'd1, 16'd0, 1'b0);
        do_start();
        send("mid_b1", 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_count", {24'd0, match_count}, 0);
        do_start();
        chk("mid_rst_nocfg", {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
